gpio_pad_ctrl: RTL and testbench



---
 rtl/gpio_pad_ctrl_if.sv | 42 ++++
 rtl/gpio_pad_ctrl.sv | 149 ++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_ctrl_if.sv
// -----------------------------------------------------------------------------
// gpio_pad_ctrl_if
// Bundles every register-side and pad-side signal of gpio_pad_ctrl.
//   master : register block / pad ring side (drives DIR/EN/OUT/toggle/irq
//            configuration and the raw pad inputs, receives updates)
//   slave  : gpio_pad_ctrl itself
// Signal names keep their direction suffix as seen from gpio_pad_ctrl.
// -----------------------------------------------------------------------------
interface gpio_pad_ctrl_if #(
    parameter int GpioCount = 16
);
    logic [GpioCount-1:0] dir_i;
    logic [GpioCount-1:0] en_i;
    logic [GpioCount-1:0] out_i;
    logic [GpioCount-1:0] toggle_i;
    logic [GpioCount-1:0] intrpt_en_i;
    logic [GpioCount-1:0] intrpt_edge_i;
    logic [GpioCount-1:0] intrpt_i;
    logic [GpioCount-1:0] gpio_in_i;
    logic [GpioCount-1:0] gpio_out_o;
    logic [GpioCount-1:0] gpio_out_en_o;
    logic [GpioCount-1:0] sync_in_o;
    logic [GpioCount-1:0] out_o;
    logic [GpioCount-1:0] out_valid_o;
    logic [GpioCount-1:0] intrpt_o;
    logic [GpioCount-1:0] intrpt_valid_o;
    logic                 irq_o;

    modport master (
        output dir_i, en_i, out_i, toggle_i, intrpt_en_i, intrpt_edge_i,
               intrpt_i, gpio_in_i,
        input  gpio_out_o, gpio_out_en_o, sync_in_o, out_o, out_valid_o,
               intrpt_o, intrpt_valid_o, irq_o
    );

    modport slave (
        input  dir_i, en_i, out_i, toggle_i, intrpt_en_i, intrpt_edge_i,
               intrpt_i, gpio_in_i,
        output gpio_out_o, gpio_out_en_o, sync_in_o, out_o, out_valid_o,
               intrpt_o, intrpt_valid_o, irq_o
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_pad_ctrl
// GPIO control stage between the pads and the GPIO register block.
//   - synchronises (and optionally debounces) pad inputs -> sync_in_o
//   - registers pad drive value / output enable from DIR, EN, OUT
//   - turns one-cycle toggle requests into OUT write-backs (combinational)
//   - detects per-pin rising-edge / high-level interrupt events and
//     reports them as status write-backs (combinational)
//   - registers the aggregated interrupt request irq_o
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, every flop clears to 0
//   bus    : gpio_pad_ctrl_if.slave, all register and pad signals
// Optional feature macro: GPIO_DEBOUNCE_EN
//   defined   -> per-pin stability filter of DebounceCycles cycles after the
//                synchroniser; sync_in_o is the filtered value
//   undefined -> filter bypassed, no counters built
// -----------------------------------------------------------------------------
module gpio_pad_ctrl #(
    parameter int GpioCount      = 16,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    gpio_pad_ctrl_if.slave bus
);

    // Elaboration-time parameter range guards
    if (GpioCount < 1 || GpioCount > 32) begin : g_chk_count
        $error("gpio_pad_ctrl: GpioCount out of range");
    end
    if (SyncStages < 2) begin : g_chk_sync
        $error("gpio_pad_ctrl: SyncStages must be >= 2");
    end
    if (DebounceCycles < 1) begin : g_chk_deb
        $error("gpio_pad_ctrl: DebounceCycles must be >= 1");
    end

    logic [GpioCount-1:0] raw_s;
    logic [GpioCount-1:0] sync_r [SyncStages];
    logic [GpioCount-1:0] stable_s;
    logic [GpioCount-1:0] prev_r;
    logic [GpioCount-1:0] armed_s;
    logic [GpioCount-1:0] event_s;
    logic [GpioCount-1:0] out_next_s;
    logic [GpioCount-1:0] gpio_out_r;
    logic [GpioCount-1:0] gpio_out_en_r;
    logic                 irq_r;

    // Disabled pins read as 0 before they enter the synchroniser
    always_comb begin
        raw_s = bus.gpio_in_i & bus.en_i;
    end

    // Synchroniser flop chain for the asynchronous pad inputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_r[k] <= {GpioCount{1'b0}};
            end
        end else begin
            sync_r[0] <= raw_s;
            for (int k = 1; k < SyncStages; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [CntW-1:0]      cnt_r [GpioCount];
    logic [GpioCount-1:0] filt_r;

    // Stability filter: the filtered value follows the synchroniser only
    // after it has disagreed for DebounceCycles consecutive cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_r <= {GpioCount{1'b0}};
            for (int i = 0; i < GpioCount; i++) begin
                cnt_r[i] <= {CntW{1'b0}};
            end
        end else begin
            for (int i = 0; i < GpioCount; i++) begin
                if (sync_r[SyncStages-1][i] != filt_r[i]) begin
                    if (cnt_r[i] == CntLast) begin
                        filt_r[i] <= sync_r[SyncStages-1][i];
                        cnt_r[i]  <= {CntW{1'b0}};
                    end else begin
                        cnt_r[i]  <= cnt_r[i] + CntW'(1);
                    end
                end else begin
                    cnt_r[i] <= {CntW{1'b0}};
                end
            end
        end
    end

    // Filtered value is what the register block and interrupt logic see
    always_comb begin
        stable_s = filt_r;
    end
`else
    // No filter: the synchroniser output goes straight to IN
    always_comb begin
        stable_s = sync_r[SyncStages-1];
    end
`endif

    // Previous input sample for rising-edge detection, plus pad drive
    // and aggregated irq registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_r        <= {GpioCount{1'b0}};
            gpio_out_r    <= {GpioCount{1'b0}};
            gpio_out_en_r <= {GpioCount{1'b0}};
            irq_r         <= 1'b0;
        end else begin
            prev_r        <= stable_s;
            gpio_out_en_r <= bus.dir_i & bus.en_i;
            gpio_out_r    <= bus.out_i & bus.dir_i & bus.en_i;
            irq_r         <= |(bus.intrpt_i & bus.intrpt_en_i);
        end
    end

    // Interrupt events: only enabled input pins are armed; edge mode needs a
    // 0->1 transition, level mode fires every cycle while the input is high
    always_comb begin
        armed_s = bus.intrpt_en_i & bus.en_i & ~bus.dir_i;
        event_s = armed_s & stable_s & (~bus.intrpt_edge_i | ~prev_r);
    end

    // Toggle write-back: toggled pins flip OUT regardless of DIR/EN
    always_comb begin
        out_next_s = bus.out_i ^ bus.toggle_i;
    end

    assign bus.sync_in_o      = stable_s;
    assign bus.gpio_out_o     = gpio_out_r;
    assign bus.gpio_out_en_o  = gpio_out_en_r;
    assign bus.out_o          = out_next_s;
    assign bus.out_valid_o    = bus.toggle_i;
    assign bus.intrpt_o       = event_s;
    assign bus.intrpt_valid_o = event_s;
    assign bus.irq_o          = irq_r;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_pad_ctrl
// Scoreboard bench for gpio_pad_ctrl. Each stimulus step pushes the values
// the outputs must show a known number of cycles later; a negedge monitor
// pops due entries and compares them. Build with +define+GPIO_DEBOUNCE_EN to
// also exercise the debounce filter (latencies shift by DebounceCycles).
// -----------------------------------------------------------------------------
module tb_gpio_pad_ctrl;

    localparam int N = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int XL = 4;
`else
    localparam int XL = 0;
`endif

    localparam int S_SYNC = 0, S_GOUT = 1, S_GOEN = 2, S_OUT = 3,
                   S_OUTV = 4, S_INT = 5, S_INTV = 6, S_IRQ = 7;

    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    gpio_pad_ctrl_if #(.GpioCount(N)) bus ();

    gpio_pad_ctrl #(
        .GpioCount(N), .SyncStages(2), .DebounceCycles(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [15:0] act,
                            input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] sample(input int sel);
        case (sel)
            S_SYNC:  sample = bus.sync_in_o;
            S_GOUT:  sample = bus.gpio_out_o;
            S_GOEN:  sample = bus.gpio_out_en_o;
            S_OUT:   sample = bus.out_o;
            S_OUTV:  sample = bus.out_valid_o;
            S_INT:   sample = bus.intrpt_o;
            S_INTV:  sample = bus.intrpt_valid_o;
            S_IRQ:   sample = {15'd0, bus.irq_o};
            default: sample = 16'hDEAD;
        endcase
    endfunction

    task automatic expect_at(input int dly, input int sel,
                             input logic [15:0] v, input string tag);
        exp_t e;
        e.due = cyc + dly;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Interrupt-valid expectation over a window: v at cycle d in [lo,hi]
    task automatic expect_intv_win(input int span, input int lo, input int hi,
                                   input logic [15:0] v, input string tag);
        for (int d = 0; d <= span; d++) begin
            expect_at(d, S_INTV, (d >= lo && d <= hi) ? v : 16'h0000, tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every scoreboard entry that falls due this cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_eq(sb_q[i].tag, sample(sb_q[i].sel), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.dir_i = '0; bus.en_i = '0; bus.out_i = '0; bus.toggle_i = '0;
        bus.intrpt_en_i = '0; bus.intrpt_edge_i = '0; bus.intrpt_i = '0;
        bus.gpio_in_i = '0;
        tick(2);

        // Reset state
        expect_at(0, S_SYNC, 16'h0000, "rst_sync");
        expect_at(0, S_GOUT, 16'h0000, "rst_gout");
        expect_at(0, S_GOEN, 16'h0000, "rst_goen");
        expect_at(0, S_IRQ,  16'h0000, "rst_irq");
        tick(1);
        rst_n = 1'b1;

        // Input path latency on pin0
        bus.en_i = 16'h0001; bus.gpio_in_i = 16'h0001;
        expect_at(1 + XL, S_SYNC, 16'h0000, "sync_early");
        expect_at(2 + XL, S_SYNC, 16'h0001, "sync_pin0");
        expect_at(1, S_GOEN, 16'h0000, "goen_input");
        tick(4 + XL);

        // Pad drive and output enable
        bus.gpio_in_i = 16'h0000;
        bus.dir_i = 16'h00F0; bus.en_i = 16'h00F0; bus.out_i = 16'h00A0;
        expect_at(0, S_GOUT, 16'h0000, "gout_before");
        expect_at(1, S_GOUT, 16'h00A0, "gout_a0");
        expect_at(1, S_GOEN, 16'h00F0, "goen_f0");
        tick(1);
        bus.out_i = 16'h0F00;
        expect_at(1, S_GOUT, 16'h0000, "gout_masked");
        expect_at(1, S_GOEN, 16'h00F0, "goen_hold");
        tick(2);

        // Toggle write-back, including pins that are not driven
        bus.out_i = 16'h0005; bus.toggle_i = 16'h0003;
        expect_at(0, S_OUTV, 16'h0003, "tog_valid");
        expect_at(0, S_OUT,  16'h0006, "tog_out");
        tick(1);
        bus.toggle_i = 16'h0000;
        expect_at(0, S_OUTV, 16'h0000, "tog_noval");
        expect_at(0, S_OUT,  16'h0005, "tog_pass");
        expect_at(0, S_GOUT, 16'h0000, "tog_undriven");
        tick(2);

        // Edge mode on pin3: one event for a held high level
        bus.dir_i = 16'h0000; bus.en_i = 16'h0008; bus.out_i = 16'h0000;
        bus.intrpt_en_i = 16'h0008; bus.intrpt_edge_i = 16'h0008;
        tick(6 + XL);
        bus.gpio_in_i = 16'h0008;
        expect_intv_win(11, 2 + XL, 2 + XL, 16'h0008, "edge_intv");
        expect_at(2 + XL, S_INT, 16'h0008, "edge_int");
        tick(12);
        bus.intrpt_i = 16'h0008;
        expect_at(0, S_IRQ, 16'h0000, "irq_lat0");
        expect_at(1, S_IRQ, 16'h0001, "irq_set");
        tick(2);
        bus.intrpt_en_i = 16'h0000;
        expect_at(1, S_IRQ, 16'h0000, "irq_masked");
        tick(2);
        // Enabling while already high in edge mode gives no event
        bus.intrpt_en_i = 16'h0008;
        expect_intv_win(4, 1, 0, 16'h0000, "en_high_noev");
        tick(6);

        // Level mode on pin3: pad high 5 cycles
        bus.intrpt_i = 16'h0000;
        bus.gpio_in_i = 16'h0000;
        tick(8 + 2 * XL);
        bus.intrpt_edge_i = 16'h0000;
        bus.gpio_in_i = 16'h0008;
        expect_intv_win(12, 2 + XL, 6 + XL, 16'h0008, "level_intv");
        tick(5);
        bus.gpio_in_i = 16'h0000;
        tick(9);

        // en 0->1 with pad high gives one edge event after sync latency
        bus.intrpt_edge_i = 16'h0008; bus.en_i = 16'h0000;
        bus.gpio_in_i = 16'h0008;
        tick(6 + XL);
        bus.en_i = 16'h0008;
        expect_intv_win(9, 2 + XL, 2 + XL, 16'h0008, "en_rise_intv");
        tick(10 + XL);

        // dir 1->0 while input stays high: no spurious edge
        bus.dir_i = 16'h0008;
        tick(4);
        bus.dir_i = 16'h0000;
        expect_intv_win(4, 1, 0, 16'h0000, "dir_fall_noev");
        tick(6);

        // Reset in the middle of operation
        bus.dir_i = 16'h0010; bus.en_i = 16'h0018; bus.out_i = 16'h0010;
        bus.intrpt_i = 16'h0008;
        tick(2);
        expect_at(0, S_GOUT, 16'h0010, "pre_rst_gout");
        expect_at(0, S_IRQ,  16'h0001, "pre_rst_irq");
        expect_at(0, S_SYNC, 16'h0008, "pre_rst_sync");
        tick(1);
        rst_n = 1'b0;
        expect_at(0, S_SYNC, 16'h0000, "mid_rst_sync");
        expect_at(0, S_GOUT, 16'h0000, "mid_rst_gout");
        expect_at(0, S_GOEN, 16'h0000, "mid_rst_goen");
        expect_at(0, S_IRQ,  16'h0000, "mid_rst_irq");
        tick(2);
        rst_n = 1'b1;
        bus.intrpt_i = 16'h0000;
        expect_at(1, S_GOUT, 16'h0010, "post_rst_gout");
        expect_intv_win(8 + XL, 2 + XL, 2 + XL, 16'h0008, "post_rst_edge");
        tick(10 + XL);

`ifdef GPIO_DEBOUNCE_EN
        // Glitch filter on pin1
        bus.dir_i = 16'h0000; bus.en_i = 16'h0002; bus.intrpt_en_i = 16'h0000;
        bus.gpio_in_i = 16'h0000;
        tick(12);
        bus.gpio_in_i = 16'h0002;
        for (int d = 0; d <= 12; d++) begin
            expect_at(d, S_SYNC, 16'h0000, "deb_glitch");
        end
        tick(2);
        bus.gpio_in_i = 16'h0000;
        tick(12);
        bus.gpio_in_i = 16'h0002;
        expect_at(5, S_SYNC, 16'h0000, "deb_wait");
        expect_at(6, S_SYNC, 16'h0002, "deb_pass");
        tick(6);
        bus.gpio_in_i = 16'h0000;
        tick(14);
`endif

        // Drain: any entry left over counts as a failed comparison
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            tick(1);
        end
        check_eq("sb_drain", 16'(sb_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
